flip_ctrl: RTL and testbench
============================

FLIP_CTRL -- requirements
Module: flip_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 4: number of consecutive rising edges need_flip must be sampled high before an actuator request is raised; legal range 1..15.
REQ-002 Parameter ACK_TIMEOUT, default 16: maximum number of cycles act_req waits for act_ack; legal range 2..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 status  input  2  cooking stage from the upstream controller: 00 raw, 01 cooking, 10 cooked, 11 burnt.
REQ-006 need_flip  input  1  upstream flip request level.
REQ-007 act_ack  input  1  actuator acknowledge level.
REQ-008 act_req  output  1  actuator request level.
REQ-009 flip  output  1  one-cycle pulse returned to the upstream controller's flip input.
REQ-010 flip_cnt  output  4  number of completed flips, saturating.
REQ-011 done  output  1  product cooked and stable.
REQ-012 alarm  output  1  sticky fault: burnt or actuator timeout.
REQ-013 err_tmo  output  1  sticky flag: the fault was an actuator timeout.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, REQ, FLIP, REL, DONE and ALARM; all outputs SHALL be decoded from registered state and counters only, with no combinational path from any input to any output.
REQ-015 Global priority: in any non-ALARM state, status==11 at a clock edge SHALL move the FSM to ALARM, overriding every other transition.
REQ-016 IDLE: need_flip=1 -> WAIT with deb_cnt=1; else status==10 -> DONE; else stay.
REQ-017 WAIT: need_flip=0 -> IDLE with deb_cnt cleared; else if deb_cnt==DEBOUNCE -> REQ with tmo_cnt=0; else deb_cnt increments. With DEBOUNCE=1, the edge after entering WAIT SHALL go to REQ.
REQ-018 REQ: act_req=1; act_ack=1 -> FLIP; else if tmo_cnt==ACK_TIMEOUT-1 -> ALARM with err_tmo set; else tmo_cnt increments. need_flip falling while in REQ SHALL NOT abort the request.
REQ-019 FLIP: flip=1 for exactly one cycle; act_req stays 1; flip_cnt increments, saturating at 15; next state is REL unconditionally.
REQ-020 REL: act_req=0; stay until act_ack=0, then IDLE; REL has no timeout.
REQ-021 DONE: done=1; status==10 -> stay; status 00 or 01 -> IDLE.
REQ-022 ALARM: alarm=1, act_req=0, flip=0; the only exit is reset.
REQ-023 flip SHALL never be high in two consecutive cycles; at least DEBOUNCE+2 cycles SHALL separate two flip pulses.
REQ-024 act_ack high in any state other than REQ or REL SHALL be ignored.
REQ-025 deb_cnt SHALL be 4 bits and tmo_cnt 8 bits; neither counter wraps within its legal range.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, deb_cnt=0, tmo_cnt=0, flip_cnt=0, act_req=0, flip=0, done=0, alarm=0 and err_tmo=0.
REQ-027 Reset asserted in any state, including mid-handshake in REQ or FLIP, SHALL drop act_req and flip in the same cycle; the first state update after release occurs on the first rising clk edge with reset=1.
REQ-028 After reset there SHALL be no memory of the previous flip_cnt or alarm.

Verification (DEBOUNCE=4, ACK_TIMEOUT=16)
REQ-029 need_flip high continuously, act_ack rising 2 cycles after act_req -> act_req rises on the 4th edge after WAIT entry; flip pulses for one cycle; flip_cnt=1; act_req falls in REL; return to IDLE after act_ack=0.
REQ-030 need_flip high for 3 edges, then low for 1, then high for 4 -> no request from the first burst; act_req rises only after the second burst of 4.
REQ-031 In REQ, act_ack held 0 -> alarm=1 and err_tmo=1 after exactly 16 cycles in REQ; act_req=0; state persists with need_flip toggling.
REQ-032 status=11 while in WAIT -> next edge alarm=1, err_tmo=0; status=10 from IDLE -> done=1; status returning to 01 -> done=0 and IDLE.
REQ-033 Run 17 complete flip handshakes -> flip_cnt saturates at 15; asynchronous reset=0 asserted mid-REQ -> act_req=0 and flip_cnt=0 with no clock edge.

Source files
------------

// File: rtl/flip_if.sv
// Handshake bundle between the upstream cook controller, the flip sequencer
// and the flipping actuator.
interface flip_if;
  logic [1:0] status;
  logic       need_flip;
  logic       act_ack;
  logic       act_req;
  logic       flip;
  logic [3:0] flip_cnt;
  logic       done;
  logic       alarm;
  logic       err_tmo;

  modport master (
    output status, need_flip, act_ack,
    input  act_req, flip, flip_cnt, done, alarm, err_tmo
  );

  modport slave (
    input  status, need_flip, act_ack,
    output act_req, flip, flip_cnt, done, alarm, err_tmo
  );
endinterface

// File: rtl/flip_ctrl.sv
// Flip sequencer: debounces the upstream flip request, runs a timed
// request/acknowledge handshake with the actuator and counts completed flips.
module flip_ctrl #(
  parameter int DEBOUNCE    = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic   clk,
  input  logic   reset,
  flip_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REQ, S_FLIP, S_REL, S_DONE, S_ALARM
  } state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [3:0] deb_cnt_reg, deb_cnt_next;
  logic [7:0] tmo_cnt_reg, tmo_cnt_next;
  logic [3:0] flip_cnt_reg, flip_cnt_next;
  logic       err_tmo_reg, err_tmo_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      deb_cnt_reg  <= '0;
      tmo_cnt_reg  <= '0;
      flip_cnt_reg <= '0;
      err_tmo_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      deb_cnt_reg  <= deb_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      flip_cnt_reg <= flip_cnt_next;
      err_tmo_reg  <= err_tmo_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    deb_cnt_next  = deb_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    flip_cnt_next = flip_cnt_reg;
    err_tmo_next  = err_tmo_reg;
    // A burnt product overrides every other transition; ALARM only leaves on reset
    if (state_reg != S_ALARM && bus.status == 2'b11) begin
      state_next = S_ALARM;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.need_flip) begin
            state_next   = S_WAIT;
            deb_cnt_next = 4'd1;
          end else if (bus.status == 2'b10) begin
            state_next = S_DONE;
          end
        end
        S_WAIT: begin
          if (!bus.need_flip) begin
            state_next   = S_IDLE;
            deb_cnt_next = '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_next   = S_REQ;
            deb_cnt_next = '0;
            tmo_cnt_next = '0;
          end else begin
            deb_cnt_next = deb_cnt_reg + 4'd1;
          end
        end
        S_REQ: begin
          if (bus.act_ack) begin
            state_next = S_FLIP;
            if (flip_cnt_reg != 4'hF) flip_cnt_next = flip_cnt_reg + 4'd1;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_next   = S_ALARM;
            err_tmo_next = 1'b1;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 8'd1;
          end
        end
        S_FLIP:  state_next = S_REL;
        S_REL:   if (!bus.act_ack) state_next = S_IDLE;
        S_DONE:  if (bus.status != 2'b10) state_next = S_IDLE;
        S_ALARM: state_next = S_ALARM;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.act_req  = (state_reg == S_REQ) || (state_reg == S_FLIP);
    bus.flip     = (state_reg == S_FLIP);
    bus.done     = (state_reg == S_DONE);
    bus.alarm    = (state_reg == S_ALARM);
    bus.err_tmo  = err_tmo_reg;
    bus.flip_cnt = flip_cnt_reg;
  end

endmodule

// File: tb/tb_flip_ctrl.sv
// Randomized and directed checking of flip_ctrl against a cycle model built
// from the sequencing rules, plus hand-computed scenario expectations.
module tb_flip_ctrl;
  localparam int DEB = 4;
  localparam int TMO = 16;

  localparam int P_IDLE = 0, P_WAIT = 1, P_REQ = 2, P_FLIP = 3,
                 P_REL = 4, P_DONE = 5, P_ALARM = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  flip_if bus();

  flip_ctrl #(.DEBOUNCE(DEB), .ACK_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus the run of high samples, cycles spent waiting
  // for ack, completed flips and the timeout flag.
  int m_phase, m_streak, m_wait, m_cnt;
  bit m_tmo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= P_IDLE; m_streak <= 0; m_wait <= 0; m_cnt <= 0; m_tmo <= 1'b0;
    end else if (m_phase != P_ALARM) begin
      if (bus.status == 2'b11) m_phase <= P_ALARM;
      else if (m_phase == P_IDLE) begin
        if (bus.need_flip) begin m_phase <= P_WAIT; m_streak <= 1; end
        else if (bus.status == 2'b10) m_phase <= P_DONE;
      end else if (m_phase == P_WAIT) begin
        if (!bus.need_flip) begin m_phase <= P_IDLE; m_streak <= 0; end
        else if (m_streak == DEB) begin m_phase <= P_REQ; m_wait <= 0; end
        else m_streak <= m_streak + 1;
      end else if (m_phase == P_REQ) begin
        if (bus.act_ack) begin m_phase <= P_FLIP; m_cnt <= (m_cnt < 15) ? m_cnt + 1 : 15; end
        else if (m_wait == TMO - 1) begin m_phase <= P_ALARM; m_tmo <= 1'b1; end
        else m_wait <= m_wait + 1;
      end else if (m_phase == P_FLIP) m_phase <= P_REL;
      else if (m_phase == P_REL) begin
        if (!bus.act_ack) m_phase <= P_IDLE;
      end else if (m_phase == P_DONE) begin
        if (bus.status != 2'b10) m_phase <= P_IDLE;
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Per-cycle comparison against the model, plus flip pulse spacing.
  int since_flip = 1000;
  always @(negedge clk) begin
    chk("act_req",  int'(bus.act_req),  int'(m_phase == P_REQ || m_phase == P_FLIP));
    chk("flip",     int'(bus.flip),     int'(m_phase == P_FLIP));
    chk("done",     int'(bus.done),     int'(m_phase == P_DONE));
    chk("alarm",    int'(bus.alarm),    int'(m_phase == P_ALARM));
    chk("err_tmo",  int'(bus.err_tmo),  int'(m_tmo));
    chk("flip_cnt", int'(bus.flip_cnt), m_cnt);
    if (!reset) since_flip = 1000;
    else if (bus.flip) begin
      chk("flip_gap_ok", int'(since_flip >= DEB + 2), 1);
      since_flip = 1;
    end else if (since_flip < 1000) since_flip++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic nf, input logic ack, input logic [1:0] st);
    bus.need_flip = nf; bus.act_ack = ack; bus.status = st;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk("rst_alarm", int'(bus.alarm), 0);
    chk("rst_err_tmo", int'(bus.err_tmo), 0);
    chk("rst_flip_cnt", int'(bus.flip_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    set_in(1'b0, 1'b0, 2'b00);
    #12;
    chk("reset_act_req", int'(bus.act_req), 0);
    chk("reset_flip", int'(bus.flip), 0);
    chk("reset_done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b1;

    // Continuous request: act_req on the 5th edge from first high sample
    set_in(1'b1, 1'b0, 2'b01);
    cyc(4); chk("deb_no_req", int'(bus.act_req), 0);
    cyc(1); chk("deb_req", int'(bus.act_req), 1);
    cyc(1); bus.act_ack = 1'b1;
    cyc(1); chk("flip_pulse", int'(bus.flip), 1); chk("flip_cnt1", int'(bus.flip_cnt), 1);
    set_in(1'b0, 1'b0, 2'b01);
    cyc(1); chk("rel_flip", int'(bus.flip), 0); chk("rel_req", int'(bus.act_req), 0);
    cyc(1);

    // Broken burst restarts the debounce
    bus.need_flip = 1'b1; cyc(3);
    bus.need_flip = 1'b0; cyc(1); chk("burst1_no_req", int'(bus.act_req), 0);
    bus.need_flip = 1'b1; cyc(4); chk("burst2_no_req", int'(bus.act_req), 0);
    cyc(1); chk("burst2_req", int'(bus.act_req), 1);
    bus.act_ack = 1'b1; cyc(1);
    set_in(1'b0, 1'b0, 2'b01); cyc(2);
    chk("flip_cnt2", int'(bus.flip_cnt), 2);

    // Actuator never acknowledges: 16 cycles in REQ then alarm
    bus.need_flip = 1'b1; cyc(5);
    cyc(15); chk("tmo_pending", int'(bus.alarm), 0);
    cyc(1); chk("tmo_alarm", int'(bus.alarm), 1); chk("tmo_err", int'(bus.err_tmo), 1);
    chk("tmo_req_low", int'(bus.act_req), 0);
    for (int i = 0; i < 4; i++) begin bus.need_flip = ~bus.need_flip; cyc(1); end
    chk("alarm_sticky", int'(bus.alarm), 1);
    pulse_reset();

    // Burnt while debouncing; cooked/done handling
    set_in(1'b1, 1'b0, 2'b01); cyc(2);
    bus.status = 2'b11; cyc(1);
    chk("burnt_alarm", int'(bus.alarm), 1); chk("burnt_err", int'(bus.err_tmo), 0);
    pulse_reset();
    set_in(1'b0, 1'b0, 2'b10); cyc(1); chk("done_set", int'(bus.done), 1);
    bus.status = 2'b01; cyc(1); chk("done_clr", int'(bus.done), 0);

    // Saturation after 17 flips, then async reset mid-REQ
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 1'b0, 2'b00); cyc(5);
      bus.act_ack = 1'b1; cyc(1);
      set_in(1'b0, 1'b0, 2'b00); cyc(2);
    end
    chk("flip_cnt_sat", int'(bus.flip_cnt), 15);
    bus.need_flip = 1'b1; cyc(5); chk("midreq_req", int'(bus.act_req), 1);
    #2 reset = 1'b0;
    #1 chk("async_req", int'(bus.act_req), 0); chk("async_cnt", int'(bus.flip_cnt), 0);
    @(negedge clk); reset = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 199);
      bus.status    = (r < 2) ? 2'b11 : (r < 20) ? 2'b10 : 2'($urandom_range(0, 1));
      bus.need_flip = ($urandom_range(0, 99) < 75);
      bus.act_ack   = ($urandom_range(0, 99) < 35);
      if (c % 250 == 249) pulse_reset();
      else cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
